// File: rtl/aes_key_expand_ctrl.sv
// ----------------------------------------------------------------------------
// aes_key_expand_ctrl
//
// Iterative AES-128 key-schedule sequencer. It takes a 128-bit cipher key over
// a valid/ready handshake and streams the 11 round keys (round 0..10) to the
// round engine over a second valid/ready handshake. SubWord shares a single
// S-box lookup across its four bytes, one byte per cycle.
//
// Per round: EMIT (held until the consumer takes it) -> SUB x4 -> MIX -> EMIT.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_key_valid  cipher key offered
//   o_key_ready  key accepted when high (IDLE only)
//   i_key        cipher key, w0 = i_key[127:96] .. w3 = i_key[31:0]
//   o_rk_valid   round key valid (EMIT only)
//   i_rk_ready   consumer accepts the round key
//   o_rk_data    current round key, same word order as i_key
//   o_rk_index   round number of o_rk_data, 0..10
//   o_rk_last    high with o_rk_valid on round 10
//   o_busy       high in any state other than IDLE
// ----------------------------------------------------------------------------
module aes_key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_WIDTH  = 128
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_key_valid,
    output logic                 o_key_ready,
    input  logic [KEY_WIDTH-1:0] i_key,
    output logic                 o_rk_valid,
    input  logic                 i_rk_ready,
    output logic [KEY_WIDTH-1:0] o_rk_data,
    output logic [3:0]           o_rk_index,
    output logic                 o_rk_last,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_SUB  = 2'd2,
        S_MIX  = 2'd3
    } state_t;

    // FIPS-197 forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // rcon for the round being produced, i.e. rcon(rnd + 1).
    function automatic logic [7:0] rcon_next(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KEY_WIDTH-1:0] r_cur_key;
    logic [3:0]           r_round;
    logic [1:0]           r_byte_cnt;
    logic [31:0]          r_temp;

    logic [31:0]          w_w0, w_w1, w_w2, w_w3;
    logic [31:0]          w_rot;
    logic [7:0]           w_sub_in;
    logic [7:0]           w_sbox_out;
    logic [31:0]          w_t;
    logic [31:0]          w_n0, w_n1, w_n2, w_n3;
    logic                 w_last;

    assign w_w0 = r_cur_key[127:96];
    assign w_w1 = r_cur_key[95:64];
    assign w_w2 = r_cur_key[63:32];
    assign w_w3 = r_cur_key[31:0];

    assign w_last = (r_round == NUM_ROUNDS[3:0]);

    // RotWord(w3); byte k sits at bit offset 8*(3-k), which is {~k, 3'b000}.
    assign w_rot      = {w_w3[23:0], w_w3[31:24]};
    assign w_sub_in   = w_rot[{~r_byte_cnt, 3'b000} +: 8];
    // Table entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
    assign w_sbox_out = SBOX_TBL[{~w_sub_in, 3'b000} +: 8];

    // Next round key from the completed SubWord result.
    assign w_t  = r_temp ^ {rcon_next(r_round), 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and outputs
    always_comb begin
        w_state_nxt = r_state;
        o_key_ready = 1'b0;
        o_rk_valid  = 1'b0;
        o_rk_last   = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_key_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_key_valid) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                o_rk_valid = 1'b1;
                o_rk_last  = w_last;
                if (i_rk_ready) w_state_nxt = w_last ? S_IDLE : S_SUB;
            end
            S_SUB: begin
                if (r_byte_cnt == 2'd3) w_state_nxt = S_MIX;
            end
            S_MIX: begin
                w_state_nxt = S_EMIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // rk_data/rk_index come straight from the held key and round counter, so
    // they stay stable through backpressure and keep the last value in IDLE.
    assign o_rk_data  = r_cur_key;
    assign o_rk_index = r_round;

    // Datapath
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_key  <= '0;
            r_round    <= '0;
            r_byte_cnt <= '0;
            r_temp     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_key_valid) begin
                        r_cur_key <= i_key;
                        r_round   <= '0;
                    end
                end
                S_EMIT: begin
                    if (i_rk_ready && !w_last) r_byte_cnt <= '0;
                end
                S_SUB: begin
                    r_temp[{~r_byte_cnt, 3'b000} +: 8] <= w_sbox_out;
                    r_byte_cnt                         <= r_byte_cnt + 2'd1;
                end
                S_MIX: begin
                    r_cur_key <= {w_n0, w_n1, w_n2, w_n3};
                    // Saturate rather than wrap.
                    if (!w_last) r_round <= r_round + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
module tb_aes_key_expand_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_key_valid = 1'b0;
    logic         o_key_ready;
    logic [127:0] i_key = '0;
    logic         o_rk_valid;
    logic         i_rk_ready = 1'b0;
    logic [127:0] o_rk_data;
    logic [3:0]   o_rk_index;
    logic         o_rk_last;
    logic         o_busy;

    aes_key_expand_ctrl #(.NUM_ROUNDS(10), .KEY_WIDTH(128)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_key_valid(i_key_valid), .o_key_ready(o_key_ready), .i_key(i_key),
        .o_rk_valid(o_rk_valid), .i_rk_ready(i_rk_ready), .o_rk_data(o_rk_data),
        .o_rk_index(o_rk_index), .o_rk_last(o_rk_last), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ZERO = 128'h0;
    localparam logic [127:0] K_ONES = {128{1'b1}};

    logic [127:0] a1_exp [0:10];
    vec_t         tbl[$];

    logic [127:0] got_data [0:10];
    int           got_idx  [0:10];
    logic         got_last [0:10];
    int           hs_edge  [0:10];
    int           nhs;
    int           key_edge;
    int           stall_err;
    int           flag_err;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Offer a key from a negedge; returns at the negedge after acceptance.
    task automatic load_key(input logic [127:0] k, input bit hold);
        int n = 0;
        i_key = k;
        i_key_valid = 1'b1;
        while (!o_key_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_key_ready) begin
            total++; bad++;
            $display("FAIL key_accept_timeout: key_ready stuck low");
        end
        key_edge = cyc + 1;
        @(negedge i_clk);
        if (!hold) i_key_valid = 1'b0;
    endtask

    // Consume round keys until index stop_idx (or rk_last) is taken.
    task automatic consume(input int pct, input int stop_idx, input bit noise);
        int           n = 0;
        bit           done = 0;
        bit           stalled = 0;
        logic [127:0] hold_d = '0;
        logic [3:0]   hold_i = '0;
        nhs = 0;
        while (!done && n < 600) begin
            i_rk_ready = ($urandom_range(99) < pct);
            if (noise) begin
                i_key_valid = 1'($urandom_range(1));
                i_key = {$urandom, $urandom, $urandom, $urandom};
            end
            if (int'(o_rk_index) > 10) flag_err++;
            if (o_rk_valid) begin
                if (o_rk_last != (o_rk_index == 4'd10)) flag_err++;
                if (stalled && (o_rk_data !== hold_d || o_rk_index !== hold_i)) stall_err++;
                if (i_rk_ready) begin
                    if (nhs < 11) begin
                        got_data[nhs] = o_rk_data;
                        got_idx[nhs]  = int'(o_rk_index);
                        got_last[nhs] = o_rk_last;
                        hs_edge[nhs]  = cyc + 1;
                    end
                    nhs++;
                    stalled = 0;
                    if (o_rk_last || int'(o_rk_index) == stop_idx) done = 1;
                end else begin
                    stalled = 1;
                    hold_d  = o_rk_data;
                    hold_i  = o_rk_index;
                end
            end
            @(negedge i_clk);
            n++;
        end
        i_rk_ready = 1'b0;
        if (noise) i_key_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL consume_timeout: %0d handshakes seen", nhs);
        end
    endtask

    initial begin
        int sp_err;
        int seq_err;

        a1_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        for (int i = 0; i < 11; i++) tbl.push_back('{K_A1, i, a1_exp[i]});
        tbl.push_back('{K_ZERO, 0,  128'h0});
        tbl.push_back('{K_ZERO, 1,  128'h62636363626363636263636362636363});
        tbl.push_back('{K_ZERO, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
        tbl.push_back('{K_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
        tbl.push_back('{K_ONES, 0,  K_ONES});
        tbl.push_back('{K_ONES, 1,  128'he8e9e9e917161616e8e9e9e917161616});

        stall_err = 0;
        flag_err  = 0;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_key_ready", 128'(o_key_ready), 128'd1);
        chk("rst_rk_valid",  128'(o_rk_valid),  128'd0);
        chk("rst_rk_data",   o_rk_data,         128'd0);
        chk("rst_rk_index",  128'(o_rk_index),  128'd0);
        chk("rst_rk_last",   128'(o_rk_last),   128'd0);
        chk("rst_busy",      128'(o_busy),      128'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Table-driven vectors
        foreach (tbl[v]) begin
            load_key(tbl[v].key, 1'b0);
            consume(100, 10, 1'b0);
            chk($sformatf("vec%0d_data", v), got_data[tbl[v].idx], tbl[v].exp);
            chk($sformatf("vec%0d_idx", v), 128'(got_idx[tbl[v].idx]), 128'(tbl[v].idx));
            chk($sformatf("vec%0d_last", v), 128'(got_last[tbl[v].idx]), 128'(tbl[v].idx == 10));
        end

        // Timing with rk_ready tied high
        load_key(K_A1, 1'b0);
        consume(100, 10, 1'b0);
        chk("a1_num_hs", 128'(nhs), 128'd11);
        sp_err = 0;
        for (int k = 0; k < 11; k++)
            if (hs_edge[k] - key_edge != 1 + 6 * k) sp_err++;
        chk("a1_spacing_err", 128'(sp_err), 128'd0);
        chk("a1_last_at_t61", 128'(hs_edge[10] - key_edge), 128'd61);
        chk("a1_idle_key_ready", 128'(o_key_ready), 128'd1);
        chk("a1_idle_busy", 128'(o_busy), 128'd0);

        // Backpressure ~30% ready
        load_key(K_A1, 1'b0);
        consume(30, 10, 1'b0);
        seq_err = 0;
        for (int k = 0; k < 11; k++)
            if (got_data[k] !== a1_exp[k] || got_idx[k] != k) seq_err++;
        chk("bp_seq_err", 128'(seq_err), 128'd0);
        chk("bp_num_hs", 128'(nhs), 128'd11);
        chk("bp_stall_err", 128'(stall_err), 128'd0);

        // key_valid noise while busy
        load_key(K_A1, 1'b0);
        consume(100, 10, 1'b1);
        seq_err = 0;
        for (int k = 0; k < 11; k++)
            if (got_data[k] !== a1_exp[k] || got_idx[k] != k) seq_err++;
        chk("noise_seq_err", 128'(seq_err), 128'd0);
        chk("noise_num_hs", 128'(nhs), 128'd11);

        // Reset during SUB of round 4
        load_key(K_A1, 1'b0);
        consume(100, 3, 1'b0);
        chk("mid_r3_data", got_data[3], a1_exp[3]);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_key_ready", 128'(o_key_ready), 128'd1);
        chk("mid_rst_rk_valid",  128'(o_rk_valid),  128'd0);
        chk("mid_rst_busy",      128'(o_busy),      128'd0);
        chk("mid_rst_rk_data",   o_rk_data,         128'd0);
        chk("mid_rst_rk_index",  128'(o_rk_index),  128'd0);
        i_rst_n = 1'b1;
        load_key(K_ZERO, 1'b0);
        consume(100, 10, 1'b0);
        chk("post_rst_idx0", 128'(got_idx[0]), 128'd0);
        chk("post_rst_r1", got_data[1], 128'h62636363626363636263636362636363);
        chk("post_rst_r10", got_data[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Back-to-back keys: A then B with key_valid held
        load_key(K_A1, 1'b1);
        i_key = K_ONES;
        consume(100, 10, 1'b0);
        seq_err = 0;
        for (int k = 0; k < 11; k++)
            if (got_data[k] !== a1_exp[k]) seq_err++;
        chk("b2b_a_seq_err", 128'(seq_err), 128'd0);
        chk("b2b_key_ready", 128'(o_key_ready), 128'd1);
        @(negedge i_clk);
        i_key_valid = 1'b0;
        chk("b2b_b_valid", 128'(o_rk_valid), 128'd1);
        chk("b2b_b_index", 128'(o_rk_index), 128'd0);
        chk("b2b_b_data", o_rk_data, K_ONES);
        consume(100, 10, 1'b0);
        chk("b2b_b_r1", got_data[1], 128'he8e9e9e917161616e8e9e9e917161616);

        chk("flag_err", 128'(flag_err), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
